soc_top: RTL and testbench

//  Minimal self-contained SoC: single-cycle RV32I-subset core, internal instruction ROM preloaded with a fixed

---
 rtl/butterfly_pkg.sv | 52 +++++
 rtl/butterfly_core.sv | 143 ++++++++++++++
 rtl/butterfly_regfile.sv | 29 ++
 rtl/soc_top.sv | 59 +++++
 tb/tb_soc_top.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/butterfly_pkg.sv
// Shared encodings and ALU helper for the ButterFly RV32I-subset core.
package butterfly_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLT,
    ALU_PASS_B
  } alu_op_e;

  function automatic logic [31:0] alu_exec(alu_op_e op, logic [31:0] a, logic [31:0] b);
    logic [31:0] res;
    case (op)
      ALU_ADD:    res = a + b;
      ALU_SUB:    res = a - b;
      ALU_AND:    res = a & b;
      ALU_OR:     res = a | b;
      ALU_XOR:    res = a ^ b;
      ALU_SLT:    res = {31'd0, ($signed(a) < $signed(b))};
      ALU_PASS_B: res = b;
      default:    res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/butterfly_core.sv
// Single-cycle RV32I-subset core: PC, decode, immediates, ALU, branch/jump, writeback.
module butterfly_core
  import butterfly_pkg::*;
#(
  parameter int          IMEM_AW  = 6,
  parameter int          DMEM_AW  = 6,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  output logic [IMEM_AW-1:0] o_imem_idx,
  input  logic [31:0]        i_imem_data,
  output logic [DMEM_AW-1:0] o_dmem_idx,
  output logic [31:0]        o_dmem_wdata,
  output logic               o_dmem_we,
  input  logic [31:0]        i_dmem_rdata
);

  logic [31:0] r_pc;

  logic [6:0]  w_opcode;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0] w_rs1_data, w_rs2_data;
  logic [31:0] w_alu_b, w_alu_res, w_wb_data, w_pc_plus4, w_pc_next;
  alu_op_e     w_alu_op;
  logic        w_rf_we, w_mem_we, w_wb_mem, w_wb_link;

  assign w_opcode = i_imem_data[6:0];
  assign w_rd     = i_imem_data[11:7];
  assign w_f3     = i_imem_data[14:12];
  assign w_rs1    = i_imem_data[19:15];
  assign w_rs2    = i_imem_data[24:20];
  assign w_f7     = i_imem_data[31:25];

  assign w_imm_i = {{20{i_imem_data[31]}}, i_imem_data[31:20]};
  assign w_imm_s = {{20{i_imem_data[31]}}, i_imem_data[31:25], i_imem_data[11:7]};
  assign w_imm_b = {{19{i_imem_data[31]}}, i_imem_data[31], i_imem_data[7],
                    i_imem_data[30:25], i_imem_data[11:8], 1'b0};
  assign w_imm_u = {i_imem_data[31:12], 12'd0};
  assign w_imm_j = {{11{i_imem_data[31]}}, i_imem_data[31], i_imem_data[19:12],
                    i_imem_data[20], i_imem_data[30:21], 1'b0};

  assign w_pc_plus4 = r_pc + 32'd4;

  always_comb begin
    w_rf_we   = 1'b0;
    w_mem_we  = 1'b0;
    w_wb_mem  = 1'b0;
    w_wb_link = 1'b0;
    w_alu_op  = ALU_ADD;
    w_alu_b   = w_rs2_data;
    w_pc_next = w_pc_plus4;
    case (w_opcode)
      OP_LUI: begin
        w_rf_we  = 1'b1;
        w_alu_op = ALU_PASS_B;
        w_alu_b  = w_imm_u;
      end
      OP_IMM: begin
        w_alu_b = w_imm_i;
        w_rf_we = 1'b1;
        case (w_f3)
          F3_ADD:  w_alu_op = ALU_ADD;
          F3_SLT:  w_alu_op = ALU_SLT;
          F3_XOR:  w_alu_op = ALU_XOR;
          F3_OR:   w_alu_op = ALU_OR;
          F3_AND:  w_alu_op = ALU_AND;
          default: w_rf_we  = 1'b0;
        endcase
      end
      OP_REG: begin
        if (w_f7 == F7_BASE) begin
          w_rf_we = 1'b1;
          case (w_f3)
            F3_ADD:  w_alu_op = ALU_ADD;
            F3_SLT:  w_alu_op = ALU_SLT;
            F3_XOR:  w_alu_op = ALU_XOR;
            F3_OR:   w_alu_op = ALU_OR;
            F3_AND:  w_alu_op = ALU_AND;
            default: w_rf_we  = 1'b0;
          endcase
        end else if ((w_f7 == F7_SUB) && (w_f3 == F3_ADD)) begin
          w_rf_we  = 1'b1;
          w_alu_op = ALU_SUB;
        end
      end
      OP_LOAD: begin
        if (w_f3 == F3_LW) begin
          w_rf_we  = 1'b1;
          w_wb_mem = 1'b1;
          w_alu_b  = w_imm_i;
        end
      end
      OP_STORE: begin
        if (w_f3 == F3_SW) begin
          w_mem_we = 1'b1;
          w_alu_b  = w_imm_s;
        end
      end
      OP_BRANCH: begin
        if (((w_f3 == F3_BEQ) && (w_rs1_data == w_rs2_data)) ||
            ((w_f3 == F3_BNE) && (w_rs1_data != w_rs2_data)))
          w_pc_next = r_pc + w_imm_b;
      end
      OP_JAL: begin
        w_rf_we   = 1'b1;
        w_wb_link = 1'b1;
        w_pc_next = r_pc + w_imm_j;
      end
      default: ;
    endcase
  end

  assign w_alu_res = alu_exec(w_alu_op, w_rs1_data, w_alu_b);
  assign w_wb_data = w_wb_link ? w_pc_plus4 : (w_wb_mem ? i_dmem_rdata : w_alu_res);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_pc <= RESET_PC;
    else          r_pc <= w_pc_next;
  end

  assign o_imem_idx   = r_pc[IMEM_AW+1:2];
  assign o_dmem_idx   = w_alu_res[DMEM_AW+1:2];
  assign o_dmem_wdata = w_rs2_data;
  // Stores must not land in RAM while the core is held in reset.
  assign o_dmem_we    = w_mem_we & i_rst_n;

  butterfly_regfile u_regfile (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_we     (w_rf_we),
    .i_waddr  (w_rd),
    .i_wdata  (w_wb_data),
    .i_raddr1 (w_rs1),
    .i_raddr2 (w_rs2),
    .o_rdata1 (w_rs1_data),
    .o_rdata2 (w_rs2_data)
  );

endmodule

// File: rtl/butterfly_regfile.sv
// 32x32 register file: two combinational reads, one write, x0 hard-wired to zero.
module butterfly_regfile
  import butterfly_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_raddr1,
  input  logic [4:0]  i_raddr2,
  output logic [31:0] o_rdata1,
  output logic [31:0] o_rdata2
);

  logic [31:0] regs [0:31];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int k = 0; k < 32; k++) regs[k] <= '0;
    end else if (i_we && (i_waddr != 5'd0)) begin
      regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == 5'd0) ? 32'd0 : regs[i_raddr1];
  assign o_rdata2 = (i_raddr2 == 5'd0) ? 32'd0 : regs[i_raddr2];

endmodule

// File: rtl/soc_top.sv
// ButterFly SoC: boot ROM, word-addressed data RAM and the single-cycle core.
module soc_top
  import butterfly_pkg::*;
#(
  parameter int          IMEM_WORDS = 64,
  parameter int          DMEM_WORDS = 64,
  parameter logic [31:0] RESET_PC   = 32'd0
) (
  input  logic clk_i,
  input  logic rst_n_i
);

  localparam int IMEM_AW = $clog2(IMEM_WORDS);
  localparam int DMEM_AW = $clog2(DMEM_WORDS);

  logic [IMEM_AW-1:0] w_imem_idx;
  logic [31:0]        w_imem_data;
  logic [DMEM_AW-1:0] w_dmem_idx;
  logic [31:0]        w_dmem_wdata, w_dmem_rdata;
  logic               w_dmem_we;

  logic [31:0] r_dmem [0:DMEM_WORDS-1];

  // Boot program; every other ROM word reads back as NOP.
  always_comb begin
    case (w_imem_idx)
      IMEM_AW'(0): w_imem_data = 32'h0050_0093;
      IMEM_AW'(1): w_imem_data = 32'h00A0_0113;
      IMEM_AW'(2): w_imem_data = 32'h0020_81B3;
      IMEM_AW'(3): w_imem_data = 32'h4011_0233;
      IMEM_AW'(4): w_imem_data = 32'h0030_2023;
      IMEM_AW'(5): w_imem_data = 32'h0000_2283;
      IMEM_AW'(6): w_imem_data = 32'h0000_006F;
      default:     w_imem_data = NOP_INSN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (w_dmem_we) r_dmem[w_dmem_idx] <= w_dmem_wdata;
  end

  assign w_dmem_rdata = r_dmem[w_dmem_idx];

  butterfly_core #(
    .IMEM_AW  (IMEM_AW),
    .DMEM_AW  (DMEM_AW),
    .RESET_PC (RESET_PC)
  ) u_core (
    .i_clk        (clk_i),
    .i_rst_n      (rst_n_i),
    .o_imem_idx   (w_imem_idx),
    .i_imem_data  (w_imem_data),
    .o_dmem_idx   (w_dmem_idx),
    .o_dmem_wdata (w_dmem_wdata),
    .o_dmem_we    (w_dmem_we),
    .i_dmem_rdata (w_dmem_rdata)
  );

endmodule

// File: tb/tb_soc_top.sv
// Directed bench for soc_top: expected architectural state is queued per step and checked at negedge.
module tb_soc_top;

  logic clk_i;
  logic rst_n_i;

  soc_top dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    int          kind;   // 0 = register, 1 = pc, 2 = dmem word
    int          idx;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sb[$];
  int        errors = 0;
  int        checks = 0;
  string     step_name;

  function automatic logic [31:0] observe(int kind, int idx);
    if (kind == 0)      return dut.u_core.u_regfile.regs[idx];
    else if (kind == 1) return dut.u_core.r_pc;
    else                return dut.r_dmem[idx];
  endfunction

  task automatic push(int kind, int idx, logic [31:0] exp);
    sb_entry_t e;
    e.kind = kind;
    e.idx  = idx;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    sb_entry_t   e;
    logic [31:0] got;
    string       tag;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      got = observe(e.kind, e.idx);
      if (e.kind == 0)      tag = $sformatf("%s.x%0d", step_name, e.idx);
      else if (e.kind == 1) tag = $sformatf("%s.pc", step_name);
      else                  tag = $sformatf("%s.dmem%0d", step_name, e.idx);
      checks++;
      assert (got === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%08h expected=%08h", tag, got, e.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic push_regs(logic [31:0] x1, logic [31:0] x2, logic [31:0] x3,
                           logic [31:0] x4, logic [31:0] x5, logic [31:0] pc);
    push(0, 0, 32'd0);
    push(0, 1, x1);
    push(0, 2, x2);
    push(0, 3, x3);
    push(0, 4, x4);
    push(0, 5, x5);
    push(1, 0, pc);
  endtask

  // Expected state after each of the first six retiring edges of the boot program.
  task automatic run_program(string label);
    step(); step_name = {label, "_e1"}; push_regs(5, 0, 0, 0, 0, 32'h04); drain();
    step(); step_name = {label, "_e2"}; push_regs(5, 10, 0, 0, 0, 32'h08); drain();
    step(); step_name = {label, "_e3"}; push_regs(5, 10, 15, 0, 0, 32'h0C); drain();
    step(); step_name = {label, "_e4"}; push_regs(5, 10, 15, 5, 0, 32'h10); drain();
    step(); step_name = {label, "_e5"}; push_regs(5, 10, 15, 5, 0, 32'h14);
    push(2, 0, 32'd15); drain();
    step(); step_name = {label, "_e6"}; push_regs(5, 10, 15, 5, 15, 32'h18); drain();
  endtask

  initial begin
    rst_n_i = 1'b0;

    // Power-on reset: two edges low.
    step(); step();
    step_name = "reset";
    for (int r = 0; r < 32; r++) push(0, r, 32'd0);
    push(1, 0, 32'd0);
    drain();

    rst_n_i = 1'b1;
    run_program("run");

    // Halted on jal x0,0: nothing may change for the remaining 42 of 48 cycles.
    for (int c = 0; c < 42; c++) begin
      step();
      step_name = $sformatf("halt%0d", c);
      push_regs(5, 10, 15, 5, 15, 32'h18);
      push(2, 0, 32'd15);
      drain();
    end

    // Mid-run reset: run to edge 3, then one reset edge.
    rst_n_i = 1'b0;
    step(); step();
    rst_n_i = 1'b1;
    step(); step(); step();
    step_name = "pre_mid";
    push_regs(5, 10, 15, 0, 0, 32'h0C);
    drain();
    rst_n_i = 1'b0;
    step();
    step_name = "mid_reset";
    for (int r = 0; r < 32; r++) push(0, r, 32'd0);
    push(1, 0, 32'd0);
    drain();
    rst_n_i = 1'b1;
    run_program("rerun");
    for (int c = 0; c < 4; c++) step();
    step_name = "rerun_final";
    push_regs(5, 10, 15, 5, 15, 32'h18);
    push(2, 0, 32'd15);
    drain();

    // Reset held for 10 cycles.
    rst_n_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      step_name = $sformatf("hold%0d", c);
      push_regs(0, 0, 0, 0, 0, 32'd0);
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
